butterfly_pipe: RTL
===================

# butterfly_pipe

Pipelined, parametrised radix-2 NTT butterfly with valid/ready flow control, per-operation mode selection and tag passthrough. It replaces the single-cycle combinational butterfly in the processing element's datapath. It supports Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT) for the Kyber and Dilithium moduli. Each operation's mode travels with it, so forward and inverse operations, or the two schemes, may be interleaved cycle by cycle.

## Interface
Parameters:
- W, 23: coefficient width; must be ≥ 23 so it holds q = 8380417.
- LAT, 3: pipeline depth in cycles; legal range is LAT ≥ 1.
- TAG_W, 8: width of the opaque tag carried alongside each operation.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input operation present.
- ready_o  out  1  block accepts an operation this cycle.
- a_i  in  W  coefficient a; precondition a_i < q.
- b_i  in  W  coefficient b; precondition b_i < q.
- twiddle_i  in  W  twiddle factor; precondition twiddle_i < q.
- sel_red_i  in  1  modulus select: 0 = Dilithium (q = 8380417), 1 = Kyber (q = 3329).
- sel_butterfly_i  in  1  butterfly select: 0 = Cooley-Tukey, 1 = Gentleman-Sande.
- tag_i  in  TAG_W  user tag, returned unchanged with the result.
- valid_o  out  1  result present.
- ready_i  in  1  downstream accepts the result.
- a_o  out  W  result a, always < q.
- b_o  out  W  result b, always < q.
- tag_o  out  TAG_W  tag of the result currently presented.
- busy_o  out  1  at least one operation is in flight or held at the output.

## Operation
- The block accepts an operation when valid_i && ready_o. At acceptance it captures a_i, b_i, twiddle_i, sel_red_i, sel_butterfly_i and tag_i.
- Cooley-Tukey: t = (twiddle·b) mod q; a_o = (a + t) mod q; b_o = (a − t) mod q.
- Gentleman-Sande: a_o = (a + b) mod q; b_o = (twiddle·(a − b) mod q) mod q.
- Arithmetic rules:
  - Add/sub use a W+1-bit intermediate with a single conditional ±q correction.
  - Multiply produces a full 2W-bit product, then a reduction selected by the captured sel_red.
  - All results are canonical, in the range [0, q).
- If any input is ≥ q, the outputs are undefined but the handshake behaviour is unaffected.
- The pipeline is a chain of LAT stages, each holding {valid, mode bits, tag, partial data}. The arithmetic may be distributed across stages in any way, provided the results match the equations above.
- Results are delivered strictly in order. No operation is ever dropped or duplicated.
- busy_o = OR of all stage valid bits.

## Timing
- Global stall rule: advance = !valid_o || ready_i. When advance is 1, every stage shifts forward by one; when it is 0, every stage holds.
- ready_o = advance, combinationally. There is no combinational path from valid_i to any output.
- Latency: exactly LAT cycles from acceptance to valid_o, with no stall. With continuous input and ready_i held at 1, throughput is one result per cycle.
- valid_o, a_o, b_o and tag_o remain stable while valid_o && !ready_i.
- A pipeline bubble (valid_i = 0 while advance = 1) shifts through as an invalid stage; it never produces valid_o.
- Reset, asserted at any time including mid-operation:
  - All stage valid bits go to 0, which discards in-flight operations.
  - valid_o = 0, a_o = 0, b_o = 0, tag_o = 0, busy_o = 0.
  - ready_o = 1 once rst_ni is high.
- A capture and an output handshake in the same cycle are legal and required. This is the full-throughput case.

## Configuration
- BUTTERFLY_HALF_EN:
  - Defined: for Gentleman-Sande operations only, both outputs are additionally multiplied by 2⁻¹ mod q, computed as x even ? x/2 : (x+q)/2. This folds the inverse-NTT 1/N scaling into the butterflies. Latency stays LAT. Cooley-Tukey is unaffected.
  - Undefined: no halving; Gentleman-Sande outputs follow the plain equations above.

## Test plan
- Kyber CT (sel_red = 1, sel_butterfly = 0), a = 100, b = 2, tw = 17 → a_o = 134, b_o = 66, valid_o exactly LAT cycles after acceptance, tag echoed.
- Dilithium CT wrap, a = 8380416, b = 1, tw = 1 → a_o = 0, b_o = 8380415. Also a = 0, b = 5, tw = 1 → a_o = 5, b_o = 8380412.
- Kyber GS (sel_red = 1, sel_butterfly = 1), a = 5, b = 10, tw = 1:
  - Without the macro → a_o = 15, b_o = 3324.
  - With BUTTERFLY_HALF_EN → a_o = 1672, b_o = 1662.
- Backpressure: LAT = 3, six back-to-back operations with tags 0..5 and ready_i low for 5 cycles mid-stream → ready_o low while valid_o && !ready_i, outputs held stable, all six tags delivered in order with no loss or duplication.
- Interleaved modes: alternate Kyber CT / Dilithium GS every cycle with random in-range operands → every result matches the reference model for its own captured mode, at one result per cycle.
- Reset mid-operation: assert rst_ni low with 3 operations in flight → valid_o, busy_o, a_o, b_o and tag_o all 0 immediately. After release, none of the old tags ever appears, and a new operation completes in LAT cycles.

Source files
------------

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 NTT butterfly (CT/GS, Kyber/Dilithium) with valid/ready.
// Optional BUTTERFLY_HALF_EN scales Gentleman-Sande outputs by 2^-1 mod q.
module butterfly_pipe #(
    parameter int W     = 23,
    parameter int LAT   = 3,
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [W-1:0]     twiddle_i,
    input  logic             sel_red_i,
    input  logic             sel_butterfly_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [W-1:0]     a_o,
    output logic [W-1:0]     b_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam logic [W-1:0] QD = W'(8380417);
    localparam logic [W-1:0] QK = W'(3329);

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic [W-1:0] q);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return W'(s);
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic [W-1:0] q);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (x < y) d = d + {1'b0, q};
        return W'(d);
    endfunction

    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic       kyber);
        logic [2*W-1:0] p;
        logic [2*W-1:0] r;
        p = (2*W)'(x) * (2*W)'(y);
        r = kyber ? p % (2*W)'(3329) : p % (2*W)'(8380417);
        return W'(r);
    endfunction

`ifdef BUTTERFLY_HALF_EN
    // x/2 mod q: odd values borrow one q so the shift is exact
    function automatic logic [W-1:0] half_mod(input logic [W-1:0] x,
                                              input logic [W-1:0] q);
        logic [W:0] s;
        s = x[0] ? {1'b0, x} + {1'b0, q} : {1'b0, x};
        return W'(s >> 1);
    endfunction
`endif

    logic [W-1:0] w_q;
    logic [W-1:0] w_t;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic         w_adv;

    always_comb begin
        w_q = sel_red_i ? QK : QD;
        w_t = '0;
        w_a = '0;
        w_b = '0;
        if (!sel_butterfly_i) begin
            w_t = mul_mod(twiddle_i, b_i, sel_red_i);
            w_a = add_mod(a_i, w_t, w_q);
            w_b = sub_mod(a_i, w_t, w_q);
        end else begin
            w_t = sub_mod(a_i, b_i, w_q);
            w_a = add_mod(a_i, b_i, w_q);
            w_b = mul_mod(twiddle_i, w_t, sel_red_i);
`ifdef BUTTERFLY_HALF_EN
            w_a = half_mod(w_a, w_q);
            w_b = half_mod(w_b, w_q);
`endif
        end
    end

    logic [LAT-1:0]   r_vld;
    logic [W-1:0]     r_a   [LAT];
    logic [W-1:0]     r_b   [LAT];
    logic [TAG_W-1:0] r_tag [LAT];

    // one global stall: the whole chain moves or the whole chain holds
    assign w_adv = !r_vld[LAT-1] || ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_tag[i] <= '0;
            end
        end else if (w_adv) begin
            r_vld[0] <= valid_i;
            r_a[0]   <= w_a;
            r_b[0]   <= w_b;
            r_tag[0] <= tag_i;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_a[i]   <= r_a[i-1];
                r_b[i]   <= r_b[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign ready_o = w_adv;
    assign valid_o = r_vld[LAT-1];
    assign a_o     = r_a[LAT-1];
    assign b_o     = r_b[LAT-1];
    assign tag_o   = r_tag[LAT-1];
    assign busy_o  = |r_vld;

endmodule
